// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the lw/sw data port.
// One access at a time; the data port wins ties; each access runs MEM_LAT memory cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              dm_elig, if_elig;

    // A port's req is still high during its own ready cycle; that cycle must not re-grant it.
    assign dm_elig = dm_req & ~dm_ready_q;
    assign if_elig = if_req & ~if_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_elig) begin
                    state_d     = DM_ACC;
                    cnt_d       = CNT_W'(1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_elig) begin
                    state_d    = IF_ACC;
                    cnt_d      = CNT_W'(1);
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            IF_ACC, DM_ACC: begin
                if (cnt_q == LAST_CNT) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == IF_ACC) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_ready_d = 1'b1;
                        // A store leaves the previous load data visible.
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign dm_rdata   = dm_rdata_q;
    assign dm_ready   = dm_ready_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign pipe_stall = ~reset & ((if_req & ~if_ready_q) | (dm_req & ~dm_ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a timestamp-based transaction model.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, pipe_stall;

    logic        if_req1, dm_req1, dm_we1;
    logic [31:0] if_addr1, dm_addr1, dm_wdata1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ready1, dm_ready1, mem_en1, mem_we1, pipe_stall1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .pipe_stall(pipe_stall1)
    );

    // Memory attached to the main instance: combinational read, write on the clock edge.
    logic [31:0] env_mem [32];
    logic        tb_wr_en;
    logic [4:0]  tb_wr_idx;
    logic [31:0] tb_wr_data;
    assign mem_rdata  = env_mem[mem_addr[6:2]];
    assign mem_rdata1 = mem_addr1 ^ 32'hA5A5_0000;
    always @(posedge clk) begin
        if (tb_wr_en) env_mem[tb_wr_idx] <= tb_wr_data;
        else if (mem_en && mem_we) env_mem[mem_addr[6:2]] <= mem_wdata;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] init_vals [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_mem();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tb_wr_en = 1'b1; tb_wr_idx = 5'(i); tb_wr_data = init_vals[i];
            tick();
        end
        tb_wr_en = 1'b0;
    endtask

    typedef struct {
        bit          if_req;
        logic [31:0] if_addr;
        bit          dm_req;
        bit          dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        int          exp_if_cyc;
        logic [31:0] exp_if_data;
        int          exp_dm_cyc;
        logic [31:0] exp_dm_data;
        logic [31:0] exp_first_addr;
    } vec_t;
    vec_t vecs [6];

    // Random-phase model state
    int          g_cyc, busy_until, if_rdy_at, dm_rdy_at;
    logic [31:0] ref_mem [32];
    logic [31:0] acc_addr, acc_wdata, pend_if, pend_dm, exp_if_rdata, exp_dm_rdata;
    bit          acc_we, pend_dm_store, e_if, e_dm, e_en, if_prev_rdy, dm_prev_rdy;

    initial begin
        int T, nev, seen_cnt;
        int if_got, dm_got, en_cnt, we_cnt, nacc;
        bit seen;
        logic [31:0] if_dat, dm_dat, first_addr;

        reset = 1'b1; tb_wr_en = 1'b0; tb_wr_idx = '0; tb_wr_data = '0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req1 = 0; if_addr1 = '0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = '0; dm_wdata1 = '0;

        for (int i = 0; i < 32; i++) init_vals[i] = 32'h1000_0000 + 32'(i);
        init_vals[0]  = 32'h2008_0005;
        init_vals[16] = 32'h1234_5678;
        load_mem();

        // Reset state and forced-low stall while reset is high
        if_req = 1; dm_req = 1;
        #1;
        chk("rst_stall", {31'b0, pipe_stall}, 0);
        chk("rst_if_ready", {31'b0, if_ready}, 0);
        chk("rst_dm_ready", {31'b0, dm_ready}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        if_req = 0; dm_req = 0;
        tick();
        reset = 1'b0;
        tick();

        vecs[0] = '{1, 32'h0,  0, 0, 32'h0,  32'h0,         3, 32'h2008_0005, -1, 32'h0,         32'h0};
        vecs[1] = '{1, 32'h0,  1, 0, 32'h40, 32'h0,         6, 32'h2008_0005,  3, 32'h1234_5678, 32'h40};
        vecs[2] = '{0, 32'h0,  1, 1, 32'h10, 32'hDEAD_BEEF, -1, 32'h0,         3, 32'h1234_5678, 32'h10};
        vecs[3] = '{0, 32'h0,  1, 0, 32'h10, 32'h0,        -1, 32'h0,          3, 32'hDEAD_BEEF, 32'h10};
        vecs[4] = '{1, 32'h10, 1, 0, 32'h40, 32'h0,         6, 32'hDEAD_BEEF,  3, 32'h1234_5678, 32'h40};
        vecs[5] = '{1, 32'h8,  1, 1, 32'h8,  32'hCAFE_F00D, 6, 32'hCAFE_F00D,  3, 32'h1234_5678, 32'h8};

        for (int vi = 0; vi < 6; vi++) begin
            tick();
            if_req = vecs[vi].if_req; if_addr = vecs[vi].if_addr;
            dm_req = vecs[vi].dm_req; dm_we = vecs[vi].dm_we;
            dm_addr = vecs[vi].dm_addr; dm_wdata = vecs[vi].dm_wdata;
            #1;
            chk("vec_stall", {31'b0, pipe_stall}, 1);
            if_got = -1; dm_got = -1; en_cnt = 0; we_cnt = 0; seen = 0;
            first_addr = '0; if_dat = '0; dm_dat = '0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (mem_en) begin
                    en_cnt++;
                    if (!seen) begin seen = 1; first_addr = mem_addr; end
                end
                if (mem_we) we_cnt++;
                if (if_ready && if_got < 0) begin if_got = k; if_dat = if_rdata; if_req = 0; end
                if (dm_ready && dm_got < 0) begin dm_got = k; dm_dat = dm_rdata; dm_req = 0; end
            end
            if_req = 0; dm_req = 0;
            nacc = int'(vecs[vi].if_req) + int'(vecs[vi].dm_req);
            chk("vec_if_cycle", if_got, vecs[vi].exp_if_cyc);
            chk("vec_dm_cycle", dm_got, vecs[vi].exp_dm_cyc);
            if (vecs[vi].if_req) chk("vec_if_rdata", if_dat, vecs[vi].exp_if_data);
            if (vecs[vi].dm_req) chk("vec_dm_rdata", dm_dat, vecs[vi].exp_dm_data);
            chk("vec_en_cycles", en_cnt, L * nacc);
            chk("vec_we_cycles", we_cnt, (vecs[vi].dm_req && vecs[vi].dm_we) ? L : 0);
            chk("vec_first_addr", first_addr, vecs[vi].exp_first_addr);
            $display("vec %0d: if_ready@%0d dm_ready@%0d mem_en_cycles=%0d", vi, if_got, dm_got, en_cnt);
            tick(); tick();
        end

        // Both requesters held: DM and IF alternate, one completion every L+1 cycles.
        // Requests drop at k=20 while a DM access is in flight; it still completes.
        tick();
        if_req = 1; if_addr = 32'h0; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        nev = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 20) begin if_req = 0; dm_req = 0; end
            if (if_ready || dm_ready) begin
                chk("alt_cycle", k, (L + 1) * (nev + 1));
                chk("alt_both", {31'b0, if_ready & dm_ready}, 0);
                chk("alt_port", {31'b0, dm_ready}, (nev % 2 == 0) ? 1 : 0);
                if (dm_ready) chk("alt_dm_rdata", dm_rdata, 32'h1234_5678);
                if (if_ready) chk("alt_if_rdata", if_rdata, 32'h2008_0005);
                $display("alt: %s ready at +%0d", dm_ready ? "dm" : "if", k);
                nev++;
            end
        end
        chk("alt_count", nev, 7);

        // Reset in the first access cycle of a load abandons it.
        tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        tick();
        chk("rstmid_en_before", {31'b0, mem_en}, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_stall", {31'b0, pipe_stall}, 0);
        tick();
        reset = 1'b0; dm_req = 0;
        chk("rstmid_mem_en", {31'b0, mem_en}, 0);
        chk("rstmid_mem_we", {31'b0, mem_we}, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_dm_rdata", dm_rdata, 0);
        chk("rstmid_if_rdata", if_rdata, 0);
        chk("rstmid_dm_ready", {31'b0, dm_ready}, 0);
        seen_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dm_ready || mem_en) seen_cnt++;
        end
        chk("rstmid_no_ready", seen_cnt, 0);
        $display("reset-mid-access: leftover activity cycles=%0d", seen_cnt);

        // Single-cycle-latency instance, fetch only
        tick();
        T = cyc;
        if_req1 = 1; if_addr1 = 32'h24;
        tick();
        chk("lat1_en_t1", {31'b0, mem_en1}, 1);
        chk("lat1_ready_t1", {31'b0, if_ready1}, 0);
        chk("lat1_addr", mem_addr1, 32'h24);
        tick();
        chk("lat1_en_t2", {31'b0, mem_en1}, 0);
        chk("lat1_ready_t2", {31'b0, if_ready1}, 1);
        chk("lat1_rdata", if_rdata1, 32'hA5A5_0024);
        if_req1 = 0;
        tick();
        chk("lat1_ready_t3", {31'b0, if_ready1}, 0);
        chk("lat1_idle_misc", {dm_rdata1[15:0], mem_wdata1[13:0], mem_we1, dm_ready1}, 0);
        chk("lat1_stall", {31'b0, pipe_stall1}, 0);
        $display("lat1: fetch at %0d completed at +2", T);

        // Random traffic against the transaction model
        for (int i = 0; i < 32; i++) begin
            init_vals[i] = $urandom;
            ref_mem[i] = init_vals[i];
        end
        if_req = 0; dm_req = 0;
        load_mem();
        reset = 1'b0;
        g_cyc = cyc; busy_until = cyc - 1; if_rdy_at = -100; dm_rdy_at = -100;
        exp_if_rdata = '0; exp_dm_rdata = '0; pend_if = '0; pend_dm = '0; pend_dm_store = 0;
        acc_addr = '0; acc_wdata = '0; acc_we = 0; if_prev_rdy = 0; dm_prev_rdy = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            e_if = (if_rdy_at == cyc);
            e_dm = (dm_rdy_at == cyc);
            if (e_if) exp_if_rdata = pend_if;
            if (e_dm && !pend_dm_store) exp_dm_rdata = pend_dm;
            e_en = (cyc > g_cyc) && (cyc <= busy_until);
            chk("rnd_if_ready", {31'b0, if_ready}, {31'b0, e_if});
            chk("rnd_dm_ready", {31'b0, dm_ready}, {31'b0, e_dm});
            chk("rnd_if_rdata", if_rdata, exp_if_rdata);
            chk("rnd_dm_rdata", dm_rdata, exp_dm_rdata);
            chk("rnd_mem_en", {31'b0, mem_en}, {31'b0, e_en});
            chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, e_en && acc_we});
            if (e_en) chk("rnd_mem_addr", mem_addr, acc_addr);
            if (e_en && acc_we) chk("rnd_mem_wdata", mem_wdata, acc_wdata);

            // Requesters hold a request through its ready cycle, then may issue a new one.
            if (!if_req || if_prev_rdy) begin
                if_req  = ($urandom_range(0, 99) < 50);
                if_addr = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            end
            if (!dm_req || dm_prev_rdy) begin
                dm_req   = ($urandom_range(0, 99) < 50);
                dm_we    = ($urandom_range(0, 2) == 0);
                dm_addr  = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
                dm_wdata = $urandom;
            end

            if (cyc > busy_until) begin
                if (dm_req && !e_dm) begin
                    g_cyc = cyc; busy_until = cyc + L; dm_rdy_at = cyc + L + 1;
                    acc_addr = dm_addr; acc_we = dm_we; acc_wdata = dm_wdata;
                    pend_dm_store = dm_we;
                    if (dm_we) ref_mem[dm_addr[6:2]] = dm_wdata;
                    else pend_dm = ref_mem[dm_addr[6:2]];
                    $display("rnd txn: dm %s addr=%h", dm_we ? "sw" : "lw", dm_addr);
                end else if (if_req && !e_if) begin
                    g_cyc = cyc; busy_until = cyc + L; if_rdy_at = cyc + L + 1;
                    acc_addr = if_addr; acc_we = 0;
                    pend_if = ref_mem[if_addr[6:2]];
                    $display("rnd txn: if fetch addr=%h", if_addr);
                end
            end
            #1;
            chk("rnd_stall", {31'b0, pipe_stall},
                {31'b0, (if_req && !e_if) || (dm_req && !e_dm)});
            if_prev_rdy = e_if;
            dm_prev_rdy = e_dm;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
